// File: rtl/piradip_axi4_pkg.sv
// Shared AXI4 / AXI4-Lite definitions: response codes, response type and the
// command record exchanged with the AXI4-Lite manager.
package piradip_axi4;

   typedef logic [1:0] resp_t;

   localparam resp_t AXI_RESP_OKAY   = 2'b00;
   localparam resp_t AXI_RESP_EXOKAY = 2'b01;
   localparam resp_t AXI_RESP_SLVERR = 2'b10;
   localparam resp_t AXI_RESP_DECERR = 2'b11;

   localparam int AXI_LITE_ADDR_W = 32;
   localparam int AXI_LITE_DATA_W = 32;
   localparam int AXI_LITE_STRB_W = AXI_LITE_DATA_W / 8;

   typedef struct packed {
      logic                       write;
      logic [AXI_LITE_ADDR_W-1:0] addr;
      logic [AXI_LITE_DATA_W-1:0] wdata;
      logic [AXI_LITE_STRB_W-1:0] wstrb;
   } axi_lite_cmd_t;

endpackage

// File: rtl/axi4mm_lite.sv
// AXI4-Lite bundle with manager and subordinate views.
interface axi4mm_lite
   import piradip_axi4::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic aclk,
   input logic aresetn
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   resp_t                 bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   resp_t                 rresp;
   logic                  rvalid;
   logic                  rready;

   modport MANAGER (
      input  aclk, aresetn,
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport SUBORDINATE (
      input  aclk, aresetn,
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/piradip_axi4mmlite_manager.sv
// Single-outstanding AXI4-Lite manager: a valid/ready command port in, one
// AXI4-Lite read or write out, a held response with its bus latency back.
module piradip_axi4mmlite_manager
   import piradip_axi4::*;
#(
   parameter logic [2:0] PROT       = 3'b000,
   parameter int         LAT_WIDTH  = 16,
   // Must match the widths of the connected axi4mm_lite instance.
   parameter int         ADDR_WIDTH = AXI_LITE_ADDR_W,
   parameter int         DATA_WIDTH = AXI_LITE_DATA_W,
   localparam int        STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axi4mm_lite.MANAGER           aximm,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [LAT_WIDTH-1:0]  rsp_latency
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WR_RESP, S_READ, S_RD_DATA, S_RSP
   } state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  bready_q, bready_d;
   logic                  rready_q, rready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_t                 resp_q, resp_d;
   logic [LAT_WIDTH-1:0]  lat_q, lat_d;
   logic                  aw_hs, w_hs;

   function automatic logic [LAT_WIDTH-1:0] sat_inc(input logic [LAT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(LAT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign aw_hs = awvalid_q && aximm.awready;
   assign w_hs  = wvalid_q && aximm.wready;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      lat_d       = lat_q;

      case (state_q)
         S_IDLE: begin
            // cmd_ready comes up one cycle after reset release or response drain
            cmd_ready_d = 1'b1;
            if (cmd_ready_q && cmd_valid) begin
               cmd_ready_d = 1'b0;
               write_d     = cmd_write;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               rdata_d     = '0;
               resp_d      = AXI_RESP_OKAY;
               lat_d       = '0;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               if (cmd_write) begin
                  state_d   = S_WRITE;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_READ;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            lat_d = sat_inc(lat_q);
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end
         end
         S_WR_RESP: begin
            lat_d = sat_inc(lat_q);
            if (bready_q && aximm.bvalid) begin
               bready_d    = 1'b0;
               resp_d      = aximm.bresp;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_READ: begin
            lat_d = sat_inc(lat_q);
            if (arvalid_q && aximm.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            lat_d = sat_inc(lat_q);
            if (rready_q && aximm.rvalid) begin
               rready_d    = 1'b0;
               rdata_d     = aximm.rdata;
               resp_d      = aximm.rresp;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b0;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         resp_q      <= AXI_RESP_OKAY;
         lat_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         lat_q       <= lat_d;
      end
   end

   // The captured address serves both channels; only one is ever active.
   assign aximm.awaddr  = addr_q;
   assign aximm.awprot  = PROT;
   assign aximm.awvalid = awvalid_q;
   assign aximm.wdata   = wdata_q;
   assign aximm.wstrb   = wstrb_q;
   assign aximm.wvalid  = wvalid_q;
   assign aximm.bready  = bready_q;
   assign aximm.araddr  = addr_q;
   assign aximm.arprot  = PROT;
   assign aximm.arvalid = arvalid_q;
   assign aximm.rready  = rready_q;

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_write   = write_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_latency = lat_q;

endmodule
